sid_hex_scroller: RTL and testbench

- Drives the six DE1-SoC seven-segment displays: a packed-BCD digit message scrolls right-to-left across HEX5..HEX0, one position per prescaled tick, wrapping continuously.
- Output side of the SID-digit path: the switch-matching checker consumes digits; this block renders them.
- Sits at top level next to the checker; HEX outputs go straight to pins.

---
 rtl/sid_hex_scroller_if.sv | 23 ++
 rtl/sid_hex_scroller.sv | 100 ++++++++++
 tb/tb_sid_hex_scroller.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sid_hex_scroller_if.sv
// Control and display bundle for the scrolling digit renderer.
// Segment fields keep the board pin names HEX0..HEX5.
interface sid_hex_scroller_if;
  logic       run;
  logic       restart;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;
  logic [6:0] HEX4;
  logic [6:0] HEX5;
  logic       wrap;

  modport master (
    output run, restart,
    input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, wrap
  );

  modport slave (
    input  run, restart,
    output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, wrap
  );
endinterface

// File: rtl/sid_hex_scroller.sv
// Scrolls a packed-BCD message right-to-left across HEX5..HEX0,
// one position per prescaled tick, padded by six blanks.
module sid_hex_scroller #(
  parameter int                   MSG_LEN     = 2,
  parameter logic [4*MSG_LEN-1:0] MSG         = 8'h23,
  parameter int                   TICK_CYCLES = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  sid_hex_scroller_if.slave bus
);

  localparam int L  = MSG_LEN + 6;
  localparam int PW = $clog2(L);
  localparam int CW = $clog2(TICK_CYCLES);
  localparam int IW = PW + 1;

  localparam logic [PW-1:0] PMAX  = PW'(L - 1);
  localparam logic [CW-1:0] CMAX  = CW'(TICK_CYCLES - 1);
  localparam logic [IW-1:0] LLEN  = IW'(L);
  localparam logic [6:0]    BLANK = 7'b1111111;

  logic [PW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic          wrap_q;
  logic [6:0]    hex_q [6];
  logic [6:0]    hex_d [6];

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = BLANK;
    endcase
    return s;
  endfunction

  // Window slot k reads buffer entry (ptr + 5 - k) mod L;
  // the sum is below 2L so one conditional subtract suffices.
  always_comb begin
    logic [IW-1:0] idx;
    idx = '0;
    for (int k = 0; k < 6; k++) begin
      hex_d[k] = BLANK;
      idx = {1'b0, ptr} + IW'(5 - k);
      if (idx >= LLEN)
        idx = idx - LLEN;
      if (int'(idx) < MSG_LEN)
        hex_d[k] = seg(MSG[4*(MSG_LEN-1-int'(idx)) +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= '0;
      cnt    <= '0;
      wrap_q <= 1'b0;
      for (int k = 0; k < 6; k++)
        hex_q[k] <= BLANK;
    end else begin
      wrap_q <= 1'b0;
      for (int k = 0; k < 6; k++)
        hex_q[k] <= hex_d[k];
      if (bus.restart) begin
        ptr <= '0;
        cnt <= '0;
      end else if (bus.run) begin
        if (cnt == CMAX) begin
          cnt <= '0;
          if (ptr == PMAX) begin
            ptr    <= '0;
            wrap_q <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.HEX0 = hex_q[0];
  assign bus.HEX1 = hex_q[1];
  assign bus.HEX2 = hex_q[2];
  assign bus.HEX3 = hex_q[3];
  assign bus.HEX4 = hex_q[4];
  assign bus.HEX5 = hex_q[5];
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_sid_hex_scroller.sv
// Bench for sid_hex_scroller: directed scenarios plus random
// run/restart/reset traffic against a ring-buffer reference model.
module tb_sid_hex_scroller;

  localparam int TICK = 4;
  localparam int L    = 8;
  localparam logic [6:0]  B  = 7'b1111111;
  localparam logic [41:0] F0 =
    {7'b0100100, 7'b0110000, B, B, B, B};
  localparam logic [41:0] FB = {6{B}};

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_pass = 0;

  sid_hex_scroller_if bus ();

  sid_hex_scroller #(
    .MSG_LEN    (2),
    .MSG        (8'h23),
    .TICK_CYCLES(TICK)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          m_ptr;
  int          m_cnt;
  logic        m_wrap;
  logic [41:0] m_hex;
  int          msgd [2] = '{2, 3};

  function automatic logic [6:0] segf(input int d);
    logic [6:0] t [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
      7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010,
      7'b1111000, 7'b0000000, 7'b0010000};
    return (d >= 0 && d < 10) ? t[d] : B;
  endfunction

  function automatic logic [41:0] frame(input int p);
    logic [41:0] f;
    int i;
    f = '0;
    for (int k = 0; k < 6; k++) begin
      i = (p + 5 - k) % L;
      f[7*k +: 7] = (i < 2) ? segf(msgd[i]) : B;
    end
    return f;
  endfunction

  function automatic logic [41:0] hexv();
    return {bus.HEX5, bus.HEX4, bus.HEX3,
            bus.HEX2, bus.HEX1, bus.HEX0};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step(input bit rs, input bit rn, input bit rt);
    reset       = rs;
    bus.run     = rn;
    bus.restart = rt;
    @(posedge clk);
    if (rs) begin
      m_ptr = 0; m_cnt = 0; m_wrap = 1'b0; m_hex = FB;
    end else begin
      m_hex  = frame(m_ptr);
      m_wrap = 1'b0;
      if (rt) begin
        m_ptr = 0; m_cnt = 0;
      end else if (rn) begin
        if (m_cnt + 1 == TICK) begin
          m_cnt = 0;
          m_wrap = (m_ptr == L - 1);
          m_ptr = (m_ptr + 1) % L;
        end else begin
          m_cnt++;
        end
      end
    end
    #1;
    chk("hex", 64'(hexv()), 64'(m_hex));
    chk("wrap", 64'(bus.wrap), 64'(m_wrap));
  endtask

  initial begin
    int wq [$];
    logic [41:0] h;
    bit ok;
    reset = 1'b1; bus.run = 1'b0; bus.restart = 1'b0;
    m_ptr = 0; m_cnt = 0; m_wrap = 1'b0; m_hex = FB;

    step(1, 0, 0);
    step(1, 0, 0);
    chk("rst_hex", 64'(hexv()), 64'(FB));
    chk("rst_wrap", 64'(bus.wrap), 64'd0);

    step(0, 0, 0);
    chk("first_frame", 64'(hexv()), 64'(F0));
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    chk("frozen", 64'(hexv()), 64'(F0));

    for (int i = 0; i < 32; i++) begin
      step(0, 1, 0);
      if (i == 4)  chk("p1_hex5", 64'(bus.HEX5), 64'(7'b0110000));
      if (i == 8)  chk("p2_blank", 64'(hexv()), 64'(FB));
      if (i == 12) chk("p3_hex0", 64'(bus.HEX0), 64'(7'b0100100));
      if (i == 16) chk("p4_hex1", 64'(bus.HEX1), 64'(7'b0100100));
      if (i == 28) chk("p7_hex3", 64'(bus.HEX3), 64'(7'b0110000));
    end

    for (int i = 0; i < 96; i++) begin
      step(0, 1, 0);
      if (bus.wrap) wq.push_back(i);
    end
    chk("wrap_count", 64'(wq.size()), 64'd3);
    if (wq.size() == 3) begin
      chk("wrap_gap0", 64'(wq[1] - wq[0]), 64'd32);
      chk("wrap_gap1", 64'(wq[2] - wq[1]), 64'd32);
    end

    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      step(0, 1, 0);
      ok = (m_cnt == 2);
    end
    chk("reach_cnt2", 64'(ok), 64'd1);
    h = hexv();
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    chk("freeze_hold", 64'(hexv()), 64'(h));
    step(0, 1, 0);
    step(0, 1, 0);
    chk("resume_hold", 64'(hexv() == h), 64'd1);
    step(0, 1, 0);
    chk("resume_step", 64'(hexv() != h), 64'd1);

    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      step(0, 1, 0);
      ok = (m_ptr == 5);
    end
    chk("reach_p5", 64'(ok), 64'd1);
    step(0, 1, 1);
    chk("restart_nowrap", 64'(bus.wrap), 64'd0);
    step(0, 1, 0);
    chk("restart_frame", 64'(hexv()), 64'(F0));
    step(1, 1, 1);
    chk("rst_restart", 64'(hexv()), 64'(FB));

    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      step(0, 1, 0);
      ok = (m_ptr == 6 && m_cnt == 3);
    end
    chk("reach_p6c3", 64'(ok), 64'd1);
    step(1, 1, 0);
    chk("mid_rst", 64'(hexv()), 64'(FB));
    step(0, 1, 0);
    chk("mid_rst_frame", 64'(hexv()), 64'(F0));
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    chk("mid_rst_step", 64'(hexv()), 64'(frame(1)));

    for (int i = 0; i < 400; i++)
      step($urandom_range(99) < 3, $urandom_range(99) < 75,
           $urandom_range(99) < 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
